// File: rtl/sdio_cmd_rsp_if.sv
// sdio_cmd_rsp_if: command-issue, CMD/DAT0 line and response/event signals of the SD command response receiver.
interface sdio_cmd_rsp_if;
  logic         cmd_start;
  logic [5:0]   cmd_index;
  logic [1:0]   rsp_type;
  logic         rsp_busy;
  logic         cmd_tx_done;
  logic         cmd_in;
  logic         dat0_in;
  logic         cmd_busy;
  logic [119:0] rsp_data;
  logic         cmd_done_event;
  logic         cmd_index_err_event;
  logic         cmd_end_err_event;
  logic         cmd_crc_err_event;
  logic         cmd_timeout_err_event;
  modport master (
    output cmd_start, cmd_index, rsp_type, rsp_busy, cmd_tx_done, cmd_in, dat0_in,
    input  cmd_busy, rsp_data, cmd_done_event, cmd_index_err_event, cmd_end_err_event,
           cmd_crc_err_event, cmd_timeout_err_event
  );
  modport slave (
    input  cmd_start, cmd_index, rsp_type, rsp_busy, cmd_tx_done, cmd_in, dat0_in,
    output cmd_busy, rsp_data, cmd_done_event, cmd_index_err_event, cmd_end_err_event,
           cmd_crc_err_event, cmd_timeout_err_event
  );
endinterface

// File: rtl/sdio_cmd_rsp.sv
// sdio_cmd_rsp: SD CMD-line response receiver with start/index/CRC7/end checks and NCR timeout.
// Define SDIO_CMD_RSP_BUSY_EN to add the R1b busy wait on DAT0 after the end bit.
module sdio_cmd_rsp #(
  parameter int RSP_TIMEOUT = 64
) (
  input logic           sd_clk,
  input logic           rst,
  input logic           cmd_sd_rst_i,
  sdio_cmd_rsp_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WAIT_TX, WAIT_START, RECV, BUSY, DONE} state_t;
  state_t         state_q, state_d;
  logic [5:0]     idx_q, idx_d;
  logic [1:0]     type_q, type_d;
  logic           busy_q, busy_d;
  logic [7:0]     tcnt_q, tcnt_d, bcnt_q, bcnt_d, pos;
  logic [135:0]   frame_q, frame_d;
  logic [6:0]     crc_q, crc_d, crc_nx;
  logic [2:0]     err_q, err_d;
  logic [119:0]   data_q, data_d;
  logic [4:0]     ev_q, ev_d;
  logic           fb, in_crc, last, busy_en;
`ifdef SDIO_CMD_RSP_BUSY_EN
  assign busy_en = 1'b1;
`else
  assign busy_en = 1'b0;
`endif
  always_comb begin
    fb      = bus.cmd_in ^ crc_q[6];
    crc_nx  = {crc_q[5:3], crc_q[2] ^ fb, crc_q[1:0], fb};
    pos     = bcnt_q - 8'd1;
    // R136 CRC skips the leading start/transmission/reserved byte
    in_crc  = pos >= 8'd8 && (type_q != 2'd2 || pos <= 8'd127);
    last    = bcnt_q == 8'd1;
    state_d = state_q;
    idx_d   = idx_q;
    type_d  = type_q;
    busy_d  = busy_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    frame_d = frame_q;
    crc_d   = crc_q;
    err_d   = err_q;
    data_d  = data_q;
    ev_d    = '0;
    case (state_q)
      IDLE: if (bus.cmd_start) begin
        state_d = WAIT_TX;
        idx_d   = bus.cmd_index;
        type_d  = bus.rsp_type;
        busy_d  = bus.rsp_busy;
        err_d   = '0;
      end
      WAIT_TX: if (bus.cmd_tx_done) begin
        state_d = type_q == 2'd0 ? DONE : WAIT_START;
        tcnt_d  = '0;
      end
      WAIT_START: if (!bus.cmd_in) begin
        state_d = RECV;
        bcnt_d  = type_q == 2'd2 ? 8'd135 : 8'd47;
        crc_d   = '0;
        frame_d = {frame_q[134:0], 1'b0};
      end else if (tcnt_q == 8'(RSP_TIMEOUT - 1)) begin
        state_d = IDLE;
        ev_d[0] = 1'b1;
      end else begin
        tcnt_d = tcnt_q + 8'd1;
      end
      RECV: begin
        frame_d = {frame_q[134:0], bus.cmd_in};
        crc_d   = in_crc ? crc_nx : crc_q;
        bcnt_d  = bcnt_q - 8'd1;
        if (last) begin
          err_d   = {type_q == 2'd1 && frame_d[45:40] != idx_q, !bus.cmd_in,
                     (type_q == 2'd1 || type_q == 2'd2) && frame_d[7:1] != crc_q};
          state_d = busy_q && busy_en ? BUSY : DONE;
        end
      end
      BUSY: if (bus.dat0_in) state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (state_d == DONE) begin
      ev_d   = {1'b1, err_d, 1'b0};
      data_d = type_q == 2'd0 ? data_q : type_q == 2'd2 ? frame_d[127:8] : {88'd0, frame_d[39:8]};
    end
    if (cmd_sd_rst_i) begin
      state_d = IDLE;
      tcnt_d  = '0;
      bcnt_d  = '0;
      ev_d    = '0;
      data_d  = data_q;
    end
  end
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      type_q  <= '0;
      busy_q  <= 1'b0;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      frame_q <= '0;
      crc_q   <= '0;
      err_q   <= '0;
      data_q  <= '0;
      ev_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      type_q  <= type_d;
      busy_q  <= busy_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      frame_q <= frame_d;
      crc_q   <= crc_d;
      err_q   <= err_d;
      data_q  <= data_d;
      ev_q    <= ev_d;
    end
  end
  assign bus.cmd_busy              = state_q != IDLE;
  assign bus.rsp_data              = data_q;
  assign bus.cmd_done_event        = ev_q[4];
  assign bus.cmd_index_err_event   = ev_q[3];
  assign bus.cmd_end_err_event     = ev_q[2];
  assign bus.cmd_crc_err_event     = ev_q[1];
  assign bus.cmd_timeout_err_event = ev_q[0];
endmodule

// File: doc/sdio_cmd_rsp.md
# sdio_cmd_rsp

Command-response receiver for the SD/SDIO host. It waits for the card's response on the CMD line after the host finishes sending a command, then deserializes it and checks the start bit, index, CRC7 and end bit. It times out if no response arrives. It emits single-cycle event pulses straight into the interrupt/error flag block (cmd_done_event, cmd_*_err_event) and exposes the captured response payload to the register file.

## Interface
- RSP_TIMEOUT, 64: sd_clk cycles allowed between command end and response start bit (NCR window); range 2..255.
- sd_clk  in  1  SD card clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_sd_rst  in  1  synchronous soft reset of command path.
- cmd_start  in  1  one-cycle pulse: new command issued.
- cmd_index  in  6  index of issued command, sampled on cmd_start.
- rsp_type  in  2  sampled on cmd_start: 0 none, 1 R48 (index+CRC checked), 2 R136 (CRC checked), 3 R48 no index/CRC check (R3/R4).
- rsp_busy  in  1  sampled on cmd_start; response has busy phase (R1b).
- cmd_tx_done  in  1  one-cycle pulse: last command bit driven, response window opens.
- cmd_in  in  1  CMD line, sampled each sd_clk edge.
- dat0_in  in  1  DAT0 line, busy indicator.
- cmd_busy  out  1  high from cmd_start until return to IDLE.
- rsp_data  out  120  captured response payload.
- cmd_done_event, cmd_index_err_event, cmd_end_err_event, cmd_crc_err_event, cmd_timeout_err_event  out  1 each  one-cycle event pulses.

## Operation
- States: IDLE, WAIT_TX, WAIT_START, RECV, BUSY, DONE.
- IDLE: cmd_start latches cmd_index, rsp_type and rsp_busy, and goes to WAIT_TX.
- WAIT_TX: on cmd_tx_done, go to DONE if rsp_type==0; otherwise go to WAIT_START and clear the 8-bit timeout counter.
- WAIT_START:
  - cmd_in==0 is the start bit: go to RECV, load bit counter with the frame length (48 or 136), and seed CRC7 (x^7+x^3+1, init 0) with the start bit.
  - Otherwise increment the timeout counter. On the RSP_TIMEOUT-th consecutive high sample, pulse cmd_timeout_err_event and return to IDLE. No cmd_done_event on timeout.
- RECV: shift cmd_in MSB-first into a 136-bit frame register.
  - CRC accumulation: 48-bit frames cover bits 47..8; 136-bit frames cover bits 127..8.
  - After the end bit (frame bit 0), go to DONE, or to BUSY if rsp_busy and SDIO_CMD_RSP_BUSY_EN is defined.
- Checks, evaluated at the end bit:
  - index_err: rsp_type 1 and frame[45:40] != cmd_index.
  - crc_err: rsp_type 1 or 2, and received CRC (frame[7:1]) != computed CRC.
  - end_err: frame[0]==0 (all response types).
  - The transmission bit is not checked.
- DONE, one cycle:
  - cmd_done_event=1, plus every applicable error event in the same cycle.
  - rsp_data updated: 48-bit sets [31:0]=frame[39:8] and [119:32]=0; 136-bit sets [119:0]=frame[127:8]; rsp_type 0 leaves it unchanged.
  - Then go to IDLE.
- rsp_data holds until the next completed response. It is updated even when errors are flagged.
- cmd_start outside IDLE is ignored.
- cmd_tx_done outside WAIT_TX is ignored.
- cmd_sd_rst in any state: go to IDLE and clear counters; no events. It overrides a simultaneous cmd_start. rsp_data is not cleared by cmd_sd_rst.

## Timing
- Reset values: state IDLE, cmd_busy 0, rsp_data 0, all event outputs 0.
- Event outputs are registered, one cycle wide, and never asserted back-to-back.
- rsp_type 0: cmd_done_event in the cycle after the cmd_tx_done edge.
- Response: start bit sampled at edge k after cmd_tx_done, with 1 ≤ k ≤ RSP_TIMEOUT. The end bit is sampled at edge k+47 (or k+135). cmd_done_event and rsp_data become valid in the following cycle.
- Timeout: cmd_in high at edges 1..RSP_TIMEOUT after cmd_tx_done gives cmd_timeout_err_event in the cycle after edge RSP_TIMEOUT. A start bit exactly at edge RSP_TIMEOUT is accepted.
- cmd_busy falls in the same cycle the IDLE transition takes effect, i.e. after the event cycle.

## Configuration
- SDIO_CMD_RSP_BUSY_EN defined:
  - A response with rsp_busy=1 enters BUSY after its end bit.
  - BUSY waits while dat0_in==0. The first dat0_in==1 sample moves to DONE, which issues cmd_done_event together with any latched error events.
  - There is no busy timeout; cmd_sd_rst aborts.
- Undefined: rsp_busy and dat0_in are ignored, BUSY is unreachable, and completion always follows the end bit directly.

## Test plan
- R48 good: cmd_index=0, rsp_type=1, drive frame 0x400000000095 at edge 3 → cmd_done_event only; rsp_data=0.
- Index error: same frame with cmd_index=8 → cmd_done_event + cmd_index_err_event, no CRC/end error.
- CRC and end errors:
  - Frame 0x400000000097 → done + cmd_crc_err_event only.
  - Frame 0x400000000094 → done + cmd_end_err_event only.
  - rsp_type=3 with frame 0x3F00FF8000FF (bad CRC) → done only.
- Timeout: RSP_TIMEOUT=64, cmd_in held 1 → cmd_timeout_err_event exactly 64 cycles after cmd_tx_done, no done.
- Start-bit boundary: with cmd_in=0 first sampled at edge 64, the response is accepted; the same frame starting at edge 65 → timeout.
- Abort/busy:
  - cmd_sd_rst mid-RECV → IDLE with no events; the next command completes normally.
  - With SDIO_CMD_RSP_BUSY_EN and rsp_busy=1, dat0_in held low 20 cycles past the end bit → cmd_done_event delayed until the first high sample.
